swap_cmd_sched: RTL and testbench

SWAP_CMD_SCHED -- requirements
Module: swap_cmd_sched

---
 rtl/swap_cmd_sched.sv | 138 +++++++++++++
 tb/tb_swap_cmd_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/swap_cmd_sched.sv
// Swap command scheduler: queues address-pair swap requests and issues them one
// at a time to a swap engine, muxing host write/read traffic through when idle.
module swap_cmd_sched #(
    parameter int width       = 7,
    parameter int depth       = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SWAP_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [width-1:0] req_addr_a,
    input  logic [width-1:0] req_addr_b,
    input  logic             host_we,
    input  logic [width-1:0] host_address_w,
    input  logic [depth-1:0] host_data_w,
    input  logic [width-1:0] host_address_r,
    output logic             host_stall,
    output logic             swap,
    output logic [width-1:0] address_a,
    output logic [width-1:0] address_b,
    output logic [width-1:0] address_w,
    output logic [width-1:0] address_r,
    output logic             we,
    output logic [depth-1:0] data_w,
    output logic             busy,
    output logic [2:0]       pending
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(SWAP_CYCLES + 1);

    localparam logic [2:0]       FULL     = 3'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SWAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [width-1:0] fifo_a [FIFO_DEPTH];
    logic [width-1:0] fifo_b [FIFO_DEPTH];

    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Readiness uses the registered count, so a full queue refuses even if a pop is due.
    assign req_ready = rstn && (pending != FULL);
    // Same-address swaps are no-ops: accepted but never stored.
    assign push      = req_valid && req_ready && (req_addr_a != req_addr_b);
    assign pop       = (state == IDLE) && (pending != '0) && !host_we;

    // NOTE: queue storage has no reset; validity is tracked by pending and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= req_addr_a;
            fifo_b[wr_ptr] <= req_addr_b;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            pending   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            address_a <= '0;
            address_b <= '0;
            swap      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            pending <= pending + {2'b00, push} - {2'b00, pop};
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);

            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= ISSUE;
                        address_a <= fifo_a[rd_ptr];
                        address_b <= fifo_b[rd_ptr];
                        swap      <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= BUSY;
                    cnt   <= CNT_LOAD;
                    swap  <= 1'b0;
                end
                BUSY: begin
                    if (cnt == CNT_ONE) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    swap  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        we         = 1'b0;
        address_w  = '0;
        address_r  = '0;
        data_w     = '0;
        host_stall = 1'b1;
        if (state == IDLE) begin
            we         = host_we;
            address_w  = host_address_w;
            address_r  = host_address_r;
            data_w     = host_data_w;
            host_stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_swap_cmd_sched.sv
// Bench for swap_cmd_sched: a queue-and-timer model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_swap_cmd_sched;

    localparam int W  = 7;
    localparam int D  = 8;
    localparam int FD = 4;
    localparam int SC = 3;

    logic         clk = 1'b0;
    logic         rstn;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_addr_a;
    logic [W-1:0] req_addr_b;
    logic         host_we;
    logic [W-1:0] host_address_w;
    logic [D-1:0] host_data_w;
    logic [W-1:0] host_address_r;
    logic         host_stall;
    logic         swap;
    logic [W-1:0] address_a;
    logic [W-1:0] address_b;
    logic [W-1:0] address_w;
    logic [W-1:0] address_r;
    logic         we;
    logic [D-1:0] data_w;
    logic         busy;
    logic [2:0]   pending;

    swap_cmd_sched #(.width(W), .depth(D), .FIFO_DEPTH(FD), .SWAP_CYCLES(SC)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
        .host_we(host_we), .host_address_w(host_address_w),
        .host_data_w(host_data_w), .host_address_r(host_address_r),
        .host_stall(host_stall), .swap(swap),
        .address_a(address_a), .address_b(address_b),
        .address_w(address_w), .address_r(address_r),
        .we(we), .data_w(data_w), .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: a list of pending pairs plus a count of remaining busy cycles.
    // A popped request occupies SC+1 busy cycles, the first of which carries the pulse.
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } req_t;

    req_t         m_q[$];
    int           m_busy_left = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;

    int           swap_cyc[$];
    int           swap_a[$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_q.delete();
            m_busy_left = 0;
            m_a = '0;
            m_b = '0;
        end else begin
            automatic bit   accept = req_valid && (m_q.size() != FD);
            automatic bit   take   = (m_busy_left == 0) && (m_q.size() != 0) && !host_we;
            automatic req_t r;
            cyc++;
            if (m_busy_left > 0) m_busy_left--;
            if (take) begin
                r = m_q.pop_front();
                m_a = r.a;
                m_b = r.b;
                m_busy_left = SC + 1;
            end
            if (accept && (req_addr_a != req_addr_b)) begin
                r.a = req_addr_a;
                r.b = req_addr_b;
                m_q.push_back(r);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            automatic bit idle = (m_busy_left == 0);
            check("req_ready",  32'(req_ready),  32'(rstn && (m_q.size() != FD)));
            check("pending",    32'(pending),    32'(m_q.size()));
            check("swap",       32'(swap),       32'(m_busy_left == SC + 1));
            check("busy",       32'(busy),       32'(!idle));
            check("address_a",  32'(address_a),  32'(m_a));
            check("address_b",  32'(address_b),  32'(m_b));
            check("host_stall", 32'(host_stall), 32'(!idle));
            check("we",         32'(we),         idle ? 32'(host_we) : 32'd0);
            check("address_w",  32'(address_w),  idle ? 32'(host_address_w) : 32'd0);
            check("address_r",  32'(address_r),  idle ? 32'(host_address_r) : 32'd0);
            check("data_w",     32'(data_w),     idle ? 32'(host_data_w) : 32'd0);
            if (rstn && swap === 1'b1) begin
                swap_cyc.push_back(cyc);
                swap_a.push_back(int'(address_a));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && busy; k++) step();
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int cnt;
        int exp_order[5];
        exp_order = '{1, 3, 5, 7, 9};

        rstn = 0; req_valid = 0; req_addr_a = '0; req_addr_b = '0;
        host_we = 0; host_address_w = '0; host_data_w = '0; host_address_r = '0;
        step(); step();
        cmp_en = 1;
        step();
        check("rst_ready",   32'(req_ready), 32'd0);
        check("rst_pending", 32'(pending),   32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        rstn = 1;
        step();

        // Single swap (5,9)
        req_valid = 1; req_addr_a = 7'd5; req_addr_b = 7'd9;
        step();
        req_valid = 0;
        check("single_pend1", 32'(pending), 32'd1);
        step();
        check("single_swap", 32'(swap),      32'd1);
        check("single_a",    32'(address_a), 32'd5);
        check("single_b",    32'(address_b), 32'd9);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) cnt++;
            step();
        end
        check("single_busy_cycles", 32'(cnt), 32'd4);
        check("single_pend0", 32'(pending), 32'd0);

        // Same-address request is consumed without a swap
        base = swap_cyc.size();
        req_valid = 1; req_addr_a = 7'd3; req_addr_b = 7'd3;
        check("same_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 0;
        check("same_pend", 32'(pending), 32'd0);
        repeat (8) step();
        check("same_no_swap", 32'(swap_cyc.size()), 32'(base));

        // Fill under host write, then release with a fifth request waiting
        host_we = 1; host_address_w = 7'd2; host_data_w = 8'h11; host_address_r = 7'd4;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1;
            req_addr_a = 7'(2 * i + 1);
            req_addr_b = 7'(2 * i + 2);
            if (i < 4) step();
        end
        check("fill_pend4",  32'(pending),   32'd4);
        check("fill_ready0", 32'(req_ready), 32'd0);
        base = swap_cyc.size();
        host_we = 0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (req_ready) begin
                step();
                cnt = 1;
                break;
            end
            step();
        end
        req_valid = 0;
        check("fill_accept5", 32'(cnt), 32'd1);
        check("full_pushpop_pend4", 32'(pending), 32'd4);
        for (int k = 0; k < 60 && swap_cyc.size() < base + 5; k++) step();
        check("fill_swaps", 32'(swap_cyc.size()), 32'(base + 5));
        if (swap_cyc.size() >= base + 5) begin
            for (int k = 0; k < 5; k++)
                check("fill_order", 32'(swap_a[base + k]), 32'(exp_order[k]));
            for (int k = 1; k < 5; k++)
                check("fill_gap", 32'(swap_cyc[base + k] - swap_cyc[base + k - 1]), 32'd5);
        end
        wait_idle();

        // Host access during BUSY is blocked, passes through in IDLE
        req_valid = 1; req_addr_a = 7'd11; req_addr_b = 7'd12;
        step();
        req_valid = 0;
        step();
        step();
        host_we = 1; host_address_w = 7'd7; host_data_w = 8'hAA; host_address_r = 7'd5;
        #1;
        check("host_busy_we",    32'(we),         32'd0);
        check("host_busy_stall", 32'(host_stall), 32'd1);
        check("host_busy_addr",  32'(address_w),  32'd0);
        wait_idle();
        check("host_idle_we",    32'(we),         32'd1);
        check("host_idle_addr",  32'(address_w),  32'd7);
        check("host_idle_data",  32'(data_w),     32'hAA);
        check("host_idle_stall", 32'(host_stall), 32'd0);
        host_we = 0;
        step();

        // Push/pop on one edge, then reset during BUSY with two queued
        req_valid = 1; req_addr_a = 7'd20; req_addr_b = 7'd21;
        step();
        req_addr_a = 7'd22; req_addr_b = 7'd23;
        step();
        check("pushpop_pend1", 32'(pending), 32'd1);
        req_addr_a = 7'd24; req_addr_b = 7'd25;
        step();
        req_valid = 0;
        check("pre_rst_pend2", 32'(pending), 32'd2);
        check("pre_rst_busy",  32'(busy),    32'd1);
        #2 rstn = 0;
        #1;
        check("rst_mid_swap",    32'(swap),      32'd0);
        check("rst_mid_busy",    32'(busy),      32'd0);
        check("rst_mid_pending", 32'(pending),   32'd0);
        check("rst_mid_ready",   32'(req_ready), 32'd0);
        step();
        step();
        rstn = 1;
        base = swap_cyc.size();
        repeat (15) step();
        check("rst_no_swap", 32'(swap_cyc.size()), 32'(base));

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
